// File: rtl/mem_pkg.sv
// Shared types and constants for the memory arbiter.
// Holds the access FSM state encoding, the requester identity and the
// timing constants used by the arbiter, its winner picker and the bench.
package mem_pkg;

  // Access sequencer states: one memory access is SETUP then STROBE.
  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETUP  = 2'd1,
    ST_STROBE = 2'd2
  } arb_state_t;

  // Identity of the agent that owns the current access.
  typedef enum logic {
    REQ_CPU = 1'b0,
    REQ_LDR = 1'b1
  } req_id_t;

  // Clock cycles occupied by one memory access (SETUP + STROBE).
  localparam int ACCESS_CYCLES = 2;

  // Consecutive quiet cycles after which a loader session ends.
  localparam int LDR_TIMEOUT   = 16;
  localparam int LDR_CNT_W     = $clog2(LDR_TIMEOUT);

  // Arbitration is allowed from IDLE and, for back-to-back accesses,
  // from STROBE.
  function automatic logic is_arb_state(input arb_state_t s);
    return (s == ST_IDLE) || (s == ST_STROBE);
  endfunction

endpackage : mem_pkg

// File: rtl/mem_arb_pick.sv
// Winner selection between the CPU and the loader.
// Build option: define MEM_ARB_RR_EN for round-robin on conflict (one
// last-winner flop, reset to "loader" so the CPU wins the first conflict);
// leave it undefined for fixed priority with the CPU always winning.
module mem_arb_pick
  import mem_pkg::*;
(
`ifdef MEM_ARB_RR_EN
  input  logic    clk,
  input  logic    rstn,
  input  logic    i_update,
`endif
  input  logic    i_cpu_req,
  input  logic    i_ldr_req,
  output req_id_t o_winner,
  output logic    o_any
);

  logic w_cpu_pref;

`ifdef MEM_ARB_RR_EN
  req_id_t r_last;

  // Remember who won the most recent grant so conflicts alternate.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_last <= REQ_LDR;
    end else if (i_update) begin
      // NOTE: state flops use non-blocking assignments so every flop samples
      // pre-edge values, independent of block ordering.
      r_last <= o_winner;
    end
  end

  assign w_cpu_pref = (r_last == REQ_LDR);
`else
  assign w_cpu_pref = 1'b1;
`endif

  assign o_any = i_cpu_req | i_ldr_req;

  // Pick the winner; a lone requester always wins.
  always_comb begin
    // NOTE: defaulting the output first keeps this block free of latches
    // on paths that do not assign it.
    o_winner = REQ_CPU;
    if (i_cpu_req && i_ldr_req) begin
      o_winner = w_cpu_pref ? REQ_CPU : REQ_LDR;
    end else if (i_ldr_req) begin
      o_winner = REQ_LDR;
    end
  end

endmodule : mem_arb_pick

// File: rtl/mem_arbiter.sv
// Two-master arbiter for an asynchronous SRAM-style bus with active-low
// read (outn) and write (writen) strobes. The CPU issues single reads or
// writes; the loader streams bytes as writes to incrementing addresses.
// Every access is SETUP (address/data stable, strobes high) followed by
// STROBE (one strobe low). Arbitration happens in IDLE and STROBE so a
// continuous stream gets one access every two cycles.
// Build option: MEM_ARB_RR_EN selects round-robin conflict resolution
// (see mem_arb_pick); default is fixed CPU priority.
module mem_arbiter
  import mem_pkg::*;
#(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              rstn,
  // CPU port
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic              cpu_gnt,
  output logic [DATA_W-1:0] cpu_rdata,
  output logic              cpu_rvalid,
  // Loader port
  input  logic              ldr_start,
  input  logic [ADDR_W-1:0] ldr_base,
  input  logic              ldr_valid,
  input  logic [DATA_W-1:0] ldr_data,
  output logic              ldr_ready,
  output logic              ldr_busy,
  // Memory bus
  output logic [ADDR_W-1:0] abus,
  output logic [DATA_W-1:0] mbus_out,
  output logic              mbus_oe,
  input  logic [DATA_W-1:0] mbus_in,
  output logic              outn,
  output logic              writen
);

  localparam logic [LDR_CNT_W-1:0] IDLE_LAST = LDR_CNT_W'(LDR_TIMEOUT - 1);

  // Access sequencer state and registered bus outputs.
  arb_state_t        r_state;
  req_id_t           r_owner;
  logic              r_we;
  logic [ADDR_W-1:0] r_abus;
  logic [DATA_W-1:0] r_wdata;
  logic              r_oe;
  logic              r_outn;
  logic              r_writen;
  logic [DATA_W-1:0] r_rdata;
  logic              r_rvalid;
  logic              r_arb_en;

  // Loader session state.
  logic                 r_ldr_busy;
  logic [ADDR_W-1:0]    r_ldr_addr;
  logic [LDR_CNT_W-1:0] r_idle_cnt;

  // Arbitration wires.
  logic              w_ldr_req;
  logic              w_any_req;
  logic              w_can_grant;
  logic              w_grant;
  logic              w_gnt_cpu;
  logic              w_gnt_ldr;
  req_id_t           w_winner;
  logic [ADDR_W-1:0] w_ldr_cur;
  logic [ADDR_W-1:0] w_sel_addr;
  logic [DATA_W-1:0] w_sel_data;
  logic              w_sel_we;

  assign w_ldr_req = r_ldr_busy & ldr_valid;

  // r_arb_en is cleared asynchronously by reset and set by the first clock
  // edge afterwards, so the combinational grant pulses can never appear
  // while rstn is low or before the first edge with rstn high.
  assign w_can_grant = r_arb_en & is_arb_state(r_state);

  mem_arb_pick u_pick (
`ifdef MEM_ARB_RR_EN
    .clk       (clk),
    .rstn      (rstn),
    .i_update  (w_grant),
`endif
    .i_cpu_req (cpu_req),
    .i_ldr_req (w_ldr_req),
    .o_winner  (w_winner),
    .o_any     (w_any_req)
  );

  assign w_grant   = w_can_grant & w_any_req;
  assign w_gnt_cpu = w_grant & (w_winner == REQ_CPU);
  assign w_gnt_ldr = w_grant & (w_winner == REQ_LDR);

  // A restart in the same cycle as a loader grant writes at the new base.
  assign w_ldr_cur  = ldr_start ? ldr_base : r_ldr_addr;
  assign w_sel_addr = (w_winner == REQ_LDR) ? w_ldr_cur : cpu_addr;
  assign w_sel_data = (w_winner == REQ_LDR) ? ldr_data  : cpu_wdata;
  assign w_sel_we   = (w_winner == REQ_LDR) ? 1'b1      : cpu_we;

  // Access sequencer: grant latch, SETUP/STROBE timing, read capture.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_state  <= ST_IDLE;
      r_owner  <= REQ_CPU;
      r_we     <= 1'b0;
      r_abus   <= '0;
      r_wdata  <= '0;
      r_oe     <= 1'b0;
      r_outn   <= 1'b1;
      r_writen <= 1'b1;
      r_rdata  <= '0;
      r_rvalid <= 1'b0;
      r_arb_en <= 1'b0;
    end else begin
      r_arb_en <= 1'b1;
      r_rvalid <= 1'b0;
      case (r_state)
        ST_SETUP: begin
          r_state  <= ST_STROBE;
          r_outn   <= r_we;
          r_writen <= ~r_we;
        end
        ST_STROBE: begin
          r_state  <= ST_IDLE;
          r_outn   <= 1'b1;
          r_writen <= 1'b1;
          r_oe     <= 1'b0;
          if ((r_owner == REQ_CPU) && !r_we) begin
            r_rdata  <= mbus_in;
            r_rvalid <= 1'b1;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
      // A grant (from IDLE or STROBE) overrides the fall-back to IDLE.
      if (w_grant) begin
        r_state <= ST_SETUP;
        r_owner <= w_winner;
        r_we    <= w_sel_we;
        r_abus  <= w_sel_addr;
        r_wdata <= w_sel_data;
        r_oe    <= w_sel_we;
      end
    end
  end

  // Loader session: start/restart, address walk and quiet-cycle timeout.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_ldr_busy <= 1'b0;
      r_ldr_addr <= '0;
      r_idle_cnt <= '0;
    end else begin
      if (w_gnt_ldr) begin
        r_ldr_addr <= w_ldr_cur + ADDR_W'(1);
      end else if (ldr_start) begin
        r_ldr_addr <= ldr_base;
      end

      if (ldr_start) begin
        r_ldr_busy <= 1'b1;
        r_idle_cnt <= '0;
      end else if (r_ldr_busy) begin
        if (ldr_valid) begin
          r_idle_cnt <= '0;
        end else if (r_idle_cnt == IDLE_LAST) begin
          r_ldr_busy <= 1'b0;
          r_idle_cnt <= '0;
        end else begin
          r_idle_cnt <= r_idle_cnt + LDR_CNT_W'(1);
        end
      end
    end
  end

  assign cpu_gnt    = w_gnt_cpu;
  assign ldr_ready  = w_gnt_ldr;
  assign ldr_busy   = r_ldr_busy;
  assign cpu_rdata  = r_rdata;
  assign cpu_rvalid = r_rvalid;
  assign abus       = r_abus;
  assign mbus_out   = r_wdata;
  assign mbus_oe    = r_oe;
  assign outn       = r_outn;
  assign writen     = r_writen;

endmodule : mem_arbiter

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: a table of CPU accesses, hand-written
// loader / conflict / reset sequences, a bus memory model, and a scoreboard
// of expected bus accesses and read data checked by a bus monitor.
module tb_mem_arbiter;
  import mem_pkg::*;

`ifdef MEM_ARB_RR_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rstn = 1'b1;
  logic        cpu_req = 1'b0, cpu_we = 1'b0;
  logic [15:0] cpu_addr = '0;
  logic [7:0]  cpu_wdata = '0;
  logic        cpu_gnt, cpu_rvalid;
  logic [7:0]  cpu_rdata;
  logic        ldr_start = 1'b0, ldr_valid = 1'b0;
  logic [15:0] ldr_base = '0;
  logic [7:0]  ldr_data = '0;
  logic        ldr_ready, ldr_busy;
  logic [15:0] abus;
  logic [7:0]  mbus_out, mbus_in;
  logic        mbus_oe, outn, writen;

  always #5 clk = ~clk;

  mem_arbiter #(.ADDR_W(16), .DATA_W(8)) dut (
    .clk(clk), .rstn(rstn),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_gnt(cpu_gnt), .cpu_rdata(cpu_rdata), .cpu_rvalid(cpu_rvalid),
    .ldr_start(ldr_start), .ldr_base(ldr_base), .ldr_valid(ldr_valid), .ldr_data(ldr_data),
    .ldr_ready(ldr_ready), .ldr_busy(ldr_busy),
    .abus(abus), .mbus_out(mbus_out), .mbus_oe(mbus_oe), .mbus_in(mbus_in),
    .outn(outn), .writen(writen)
  );

  // Bus memory model: stores on write strobe, drives data on read strobe.
  logic [7:0] bmem [0:65535];
  always @(posedge clk) if (!writen) bmem[abus] <= mbus_out;
  assign mbus_in = outn ? 8'h00 : bmem[abus];

  typedef struct {
    logic        we;
    logic [15:0] addr;
    logic [7:0]  data;   // write data, or expected read data
  } acc_t;

  acc_t       acc_q[$];
  logic [7:0] rd_q[$];
  int         n_cmp = 0;
  int         n_err = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic push_acc(input logic we, input logic [15:0] addr, input logic [7:0] data);
    acc_t e;
    e.we = we; e.addr = addr; e.data = data;
    acc_q.push_back(e);
  endtask

  // Bus monitor: every strobe cycle must match the next expected access.
  acc_t mon_e;
  always @(negedge clk) begin
    if (rstn) begin
      check("strobe_excl", 32'(outn | writen), 32'd1);
      if (!outn || !writen) begin
        if (acc_q.size() == 0) begin
          check("unexpected_access", 32'(abus), 32'hFFFF_FFFF);
        end else begin
          mon_e = acc_q.pop_front();
          check("acc_dir_write", 32'(!writen), 32'(mon_e.we));
          check("acc_addr", 32'(abus), 32'(mon_e.addr));
          check("acc_oe", 32'(mbus_oe), 32'(mon_e.we));
          if (mon_e.we) check("acc_wdata", 32'(mbus_out), 32'(mon_e.data));
          else          rd_q.push_back(mon_e.data);
        end
      end
      if (cpu_rvalid) begin
        if (rd_q.size() == 0) check("unexpected_rvalid", 32'(cpu_rdata), 32'hFFFF_FFFF);
        else                  check("cpu_rdata", 32'(cpu_rdata), 32'(rd_q.pop_front()));
      end
    end
  end

  // Called just after a rising edge; returns just after a rising edge.
  task automatic cpu_access(input logic we, input logic [15:0] addr,
                            input logic [7:0] wd, input logic [7:0] exp_rd);
    bit got = 1'b0;
    cpu_req = 1'b1; cpu_we = we; cpu_addr = addr; cpu_wdata = wd;
    for (int i = 0; i < 20 && !got; i++) begin
      @(negedge clk);
      if (cpu_gnt) begin
        got = 1'b1;
        push_acc(we, addr, we ? wd : exp_rd);
      end
      @(posedge clk); #1;
    end
    cpu_req = 1'b0;
    check("cpu_gnt_seen", 32'(got), 32'd1);
  endtask

  task automatic wait_drain();
    for (int i = 0; i < 40; i++) begin
      if (acc_q.size() == 0 && rd_q.size() == 0) break;
      @(posedge clk); #1;
    end
    check("queues_drained", 32'(acc_q.size() + rd_q.size()), 32'd0);
  endtask

  typedef struct {
    logic        we;
    logic [15:0] addr;
    logic [7:0]  wdata;
    logic [7:0]  exp_rdata;
  } vec_t;

  vec_t       vecs[8];
  logic [7:0] lbytes[3];
  int         idle, ng, nl, prev;
  bit         got;

  initial begin
    for (int i = 0; i < 65536; i++) bmem[i] = 8'h00;
    vecs[0] = '{1'b0, 16'h8001, 8'h00, 8'h5A};
    vecs[1] = '{1'b1, 16'h0000, 8'hA5, 8'h00};
    vecs[2] = '{1'b1, 16'hFFFF, 8'h3C, 8'h00};
    vecs[3] = '{1'b0, 16'h0000, 8'h00, 8'hA5};
    vecs[4] = '{1'b0, 16'hFFFF, 8'h00, 8'h3C};
    vecs[5] = '{1'b1, 16'h8001, 8'hC3, 8'h00};
    vecs[6] = '{1'b0, 16'h8001, 8'h00, 8'hC3};
    vecs[7] = '{1'b0, 16'h8001, 8'h00, 8'hC3};
    lbytes = '{8'h11, 8'h22, 8'h33};

    // Reset state, with a CPU request pending that must not be granted.
    #2 rstn = 1'b0;
    cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 16'h1234;
    @(posedge clk); #1;
    check("rst_outn", 32'(outn), 32'd1);
    check("rst_writen", 32'(writen), 32'd1);
    check("rst_oe", 32'(mbus_oe), 32'd0);
    check("rst_abus", 32'(abus), 32'd0);
    check("rst_gnt", 32'(cpu_gnt), 32'd0);
    check("rst_rvalid", 32'(cpu_rvalid), 32'd0);
    check("rst_ready", 32'(ldr_ready), 32'd0);
    check("rst_busy", 32'(ldr_busy), 32'd0);
    check("rst_rdata", 32'(cpu_rdata), 32'd0);
    cpu_req = 1'b0;
    @(negedge clk); rstn = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1;

    // CPU write 0x5A to 0x8001: exact cycle-by-cycle bus timing.
    cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 16'h8001; cpu_wdata = 8'h5A;
    @(negedge clk);
    check("w_gnt_cycle0", 32'(cpu_gnt), 32'd1);
    push_acc(1'b1, 16'h8001, 8'h5A);
    @(posedge clk); #1; cpu_req = 1'b0;
    @(negedge clk);
    check("w_setup_abus", 32'(abus), 32'h8001);
    check("w_setup_oe", 32'(mbus_oe), 32'd1);
    check("w_setup_writen", 32'(writen), 32'd1);
    check("w_setup_outn", 32'(outn), 32'd1);
    @(posedge clk); #1;
    @(negedge clk);
    check("w_strobe_writen", 32'(writen), 32'd0);
    @(posedge clk); #1;
    @(negedge clk);
    check("w_after_writen", 32'(writen), 32'd1);
    check("w_after_oe", 32'(mbus_oe), 32'd0);
    @(posedge clk); #1;

    // Table of CPU accesses, issued back to back.
    for (int v = 0; v < 8; v++)
      cpu_access(vecs[v].we, vecs[v].addr, vecs[v].wdata, vecs[v].exp_rdata);
    wait_drain();

    // Loader session across the address wrap, then idle timeout.
    ldr_start = 1'b1; ldr_base = 16'hFFFE;
    @(posedge clk); #1; ldr_start = 1'b0;
    @(negedge clk);
    check("ldr_busy_set", 32'(ldr_busy), 32'd1);
    @(posedge clk); #1;
    for (int b = 0; b < 3; b++) begin
      ldr_valid = 1'b1; ldr_data = lbytes[b];
      got = 1'b0;
      for (int j = 0; j < 20 && !got; j++) begin
        @(negedge clk);
        if (ldr_ready) begin
          got = 1'b1;
          push_acc(1'b1, 16'hFFFE + 16'(b), lbytes[b]);
        end
        @(posedge clk); #1;
      end
      check("ldr_ready_seen", 32'(got), 32'd1);
    end
    ldr_valid = 1'b0;
    idle = 0;
    for (int j = 0; j < 40; j++) begin
      @(negedge clk);
      if (!ldr_busy) break;
      idle++;
      @(posedge clk); #1;
    end
    check("ldr_timeout_cycles", 32'(idle), 32'd16);
    @(posedge clk); #1;
    wait_drain();

    // Continuous conflict right after reset.
    rstn = 1'b0;
    @(posedge clk); #1;
    @(negedge clk); rstn = 1'b1;
    @(posedge clk); #1;
    ldr_start = 1'b1; ldr_base = 16'h1000;
    @(posedge clk); #1; ldr_start = 1'b0;
    cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 16'h2000; cpu_wdata = 8'hC0;
    ldr_valid = 1'b1; ldr_data = 8'h77;
    ng = 0; nl = 0; prev = 0;
    for (int c = 0; c < 40 && ng < 6; c++) begin
      @(negedge clk);
      if (cpu_gnt || ldr_ready) begin
        check("conf_excl", 32'(cpu_gnt & ldr_ready), 32'd0);
        check("conf_winner_ldr", 32'(ldr_ready), 32'(RR && (ng % 2 == 1)));
        if (ng > 0) check("conf_spacing", 32'(c - prev), 32'(ACCESS_CYCLES));
        prev = c;
        if (ldr_ready) begin
          push_acc(1'b1, 16'h1000 + 16'(nl), 8'h77);
          nl++;
        end else begin
          push_acc(1'b1, 16'h2000, 8'hC0);
        end
        ng++;
      end
      @(posedge clk); #1;
    end
    cpu_req = 1'b0; ldr_valid = 1'b0;
    check("conf_grants", 32'(ng), 32'd6);
    wait_drain();

    // Reset asserted in the STROBE cycle of a write.
    cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 16'h4444; cpu_wdata = 8'h99;
    got = 1'b0;
    for (int j = 0; j < 20 && !got; j++) begin
      @(negedge clk);
      if (cpu_gnt) begin got = 1'b1; push_acc(1'b1, 16'h4444, 8'h99); end
      @(posedge clk); #1;
    end
    check("rstw_gnt_seen", 32'(got), 32'd1);
    cpu_req = 1'b0;
    @(posedge clk); #1;
    @(negedge clk);
    check("rstw_strobe_on", 32'(writen), 32'd0);
    #2 rstn = 1'b0; cpu_req = 1'b1; ldr_valid = 1'b1;
    #1;
    check("rstw_writen_async", 32'(writen), 32'd1);
    check("rstw_outn_async", 32'(outn), 32'd1);
    check("rstw_oe_async", 32'(mbus_oe), 32'd0);
    check("rstw_rdata_clr", 32'(cpu_rdata), 32'd0);
    for (int j = 0; j < 3; j++) begin
      @(posedge clk); #1;
      @(negedge clk);
      check("rstw_no_gnt", 32'(cpu_gnt), 32'd0);
      check("rstw_no_ready", 32'(ldr_ready), 32'd0);
    end
    #2 rstn = 1'b1;
    #1 check("rstw_no_early_gnt", 32'(cpu_gnt), 32'd0);
    @(posedge clk); #1;
    @(negedge clk);
    check("rstw_first_gnt", 32'(cpu_gnt), 32'd1);
    check("rstw_ldr_idle", 32'(ldr_ready), 32'd0);
    if (cpu_gnt) push_acc(1'b1, 16'h4444, 8'h99);
    @(posedge clk); #1;
    cpu_req = 1'b0; ldr_valid = 1'b0;
    wait_drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule : tb_mem_arbiter
